// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared types, line symbols and CRC16 constants for the USB FS transmit path
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_DATA    = 3'd2,
        ST_EOP_SE0 = 3'd3,
        ST_EOP_J   = 3'd4
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // Line symbols as {dp, dm}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

    // NRZI: a 0 toggles between J and K, a 1 holds the line.
    function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic bit_val);
        logic [1:0] r;
        if (bit_val) begin
            r = line;
        end else begin
            r = (line == LINE_J) ? LINE_K : LINE_J;
        end
        return r;
    endfunction

    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// rtl/tx_bit_timer.sv - line bit timer producing one strobe every CLKS_PER_BIT cycles
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clear       : restart the count at 0 (packet start)
//   enable      : count while a packet is on the line
//   bit_strobe  : high in the last cycle of each bit time
module tx_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_strobe
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign bit_strobe = enable && (cnt == LAST);

endmodule

// File: rtl/usb_tx_crc16.sv
// rtl/usb_tx_crc16.sv - reflected CRC16 accumulator over data bytes (present only with USB_TX_CRC16_EN)
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   init     : load CRC16_INIT (packet start)
//   update   : fold data into the running CRC, LSB first
//   data     : byte to fold in
//   crc      : running (non-inverted) CRC
`ifdef USB_TX_CRC16_EN
module usb_tx_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        update,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    localparam logic [15:0] POLY_REFL = reflect16(CRC16_POLY);

    logic [15:0] crc_next;

    always_comb begin
        crc_next = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ POLY_REFL) : (crc_next >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || init) begin
            crc <= CRC16_INIT;
        end else if (update) begin
            crc <= crc_next;
        end
    end

endmodule
`endif

// File: rtl/usb_tx_serializer.sv
// rtl/usb_tx_serializer.sv - USB full-speed transmit serializer: SYNC, bit stuffing, NRZI, EOP
// Optional CRC16 append when USB_TX_CRC16_EN is defined.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   tx_start               : one-cycle packet request, ignored while tx_active
//   tx_data/tx_last        : packet byte and final-byte marker
//   tx_data_valid/ready    : byte handshake into the holding register
//   dp_out/dm_out          : differential line pair
//   tx_active              : packet in progress
//   tx_done/tx_error       : completion pulse / underrun pulse
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LEN    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       dp_out,
    output logic       dm_out,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int SW = $clog2(STUFF_LEN + 1);
    localparam logic [SW-1:0] STUFF_MAX = SW'(STUFF_LEN);

    tx_state_t   state, state_d;
    logic [1:0]  line, line_d;
    logic [7:0]  shifter, shifter_d;
    logic [2:0]  bits_left, bits_left_d;
    logic [SW-1:0] stuff_cnt, stuff_d;
    logic        cur_last, cur_last_d;
    logic [7:0]  hold_data, hold_data_d;
    logic        hold_last, hold_last_d;
    logic        hold_full, hold_full_d;
    logic        last_acc, last_acc_d;
    logic        eop_cnt, eop_cnt_d;
    logic        done_d, error_d, ready_d;

    logic        accept;
    logic        start_pkt;
    logic        bit_strobe;
    logic        emit, emit_val;
    logic        load, load_last;
    logic [7:0]  load_val;

`ifdef USB_TX_CRC16_EN
    logic [15:0] crc;
    logic [1:0]  crc_phase, crc_phase_d;

    usb_tx_crc16 u_crc (
        .clk    (clk),
        .rst    (rst),
        .init   (start_pkt),
        .update (accept),
        .data   (tx_data),
        .crc    (crc)
    );
`endif

    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_pkt),
        .enable     (state != ST_IDLE),
        .bit_strobe (bit_strobe)
    );

    assign accept = tx_data_valid && tx_data_ready;
    assign dp_out = line[1];
    assign dm_out = line[0];

    always_comb begin
        state_d     = state;
        line_d      = line;
        shifter_d   = shifter;
        bits_left_d = bits_left;
        stuff_d     = stuff_cnt;
        cur_last_d  = cur_last;
        hold_data_d = hold_data;
        hold_last_d = hold_last;
        hold_full_d = hold_full;
        last_acc_d  = last_acc;
        eop_cnt_d   = eop_cnt;
        done_d      = 1'b0;
        error_d     = 1'b0;
        start_pkt   = 1'b0;
        emit        = 1'b0;
        emit_val    = 1'b0;
        load        = 1'b0;
        load_last   = 1'b0;
        load_val    = '0;
`ifdef USB_TX_CRC16_EN
        crc_phase_d = crc_phase;
`endif

        if (accept) begin
            hold_data_d = tx_data;
            hold_last_d = tx_last;
            hold_full_d = 1'b1;
            last_acc_d  = last_acc | tx_last;
        end

        case (state)
            ST_IDLE: begin
                if (tx_start) begin
                    // SYNC is shifted like a data byte; its first bit goes out now.
                    start_pkt   = 1'b1;
                    state_d     = ST_SYNC;
                    emit        = 1'b1;
                    emit_val    = SYNC_BYTE[0];
                    shifter_d   = SYNC_BYTE >> 1;
                    bits_left_d = 3'd7;
                    cur_last_d  = 1'b0;
                    hold_full_d = 1'b0;
                    last_acc_d  = 1'b0;
`ifdef USB_TX_CRC16_EN
                    crc_phase_d = 2'd0;
`endif
                end
            end
            ST_SYNC, ST_DATA: begin
                if (bit_strobe) begin
                    if (stuff_cnt == STUFF_MAX) begin
                        // Stuffed 0 takes priority, so a pending stuff bit after
                        // the final byte is still sent before EOP.
                        emit     = 1'b1;
                        emit_val = 1'b0;
                    end else if (bits_left != 3'd0) begin
                        emit        = 1'b1;
                        emit_val    = shifter[0];
                        shifter_d   = shifter >> 1;
                        bits_left_d = bits_left - 3'd1;
                    end else if (state == ST_DATA && cur_last) begin
`ifdef USB_TX_CRC16_EN
                        if (crc_phase == 2'd0) begin
                            load        = 1'b1;
                            load_val    = ~crc[7:0];
                            load_last   = 1'b1;
                            crc_phase_d = 2'd1;
                        end else if (crc_phase == 2'd1) begin
                            load        = 1'b1;
                            load_val    = ~crc[15:8];
                            load_last   = 1'b1;
                            crc_phase_d = 2'd2;
                        end else begin
                            state_d   = ST_EOP_SE0;
                            line_d    = LINE_SE0;
                            eop_cnt_d = 1'b0;
                        end
`else
                        state_d   = ST_EOP_SE0;
                        line_d    = LINE_SE0;
                        eop_cnt_d = 1'b0;
`endif
                    end else if (hold_full) begin
                        load        = 1'b1;
                        load_val    = hold_data;
                        load_last   = hold_last;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        // Byte arriving exactly at the boundary bypasses the holding register.
                        load        = 1'b1;
                        load_val    = tx_data;
                        load_last   = tx_last;
                        hold_full_d = 1'b0;
                    end else begin
                        error_d   = 1'b1;
                        state_d   = ST_EOP_SE0;
                        line_d    = LINE_SE0;
                        eop_cnt_d = 1'b0;
                    end
                end
            end
            ST_EOP_SE0: begin
                if (bit_strobe) begin
                    if (!eop_cnt) begin
                        eop_cnt_d = 1'b1;
                    end else begin
                        state_d = ST_EOP_J;
                        line_d  = LINE_J;
                    end
                end
            end
            ST_EOP_J: begin
                if (bit_strobe) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                line_d  = LINE_J;
            end
        endcase

        if (load) begin
            emit        = 1'b1;
            emit_val    = load_val[0];
            shifter_d   = load_val >> 1;
            bits_left_d = 3'd7;
            cur_last_d  = load_last;
            state_d     = ST_DATA;
        end

        if (emit) begin
            line_d  = nrzi_next(line, emit_val);
            stuff_d = emit_val ? stuff_cnt + 1'b1 : '0;
        end

        // Bytes are only taken while they can still be shifted out; after an
        // underrun the EOP states refuse further data.
        ready_d = ((state_d == ST_SYNC) || (state_d == ST_DATA)) && !hold_full_d && !last_acc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            line          <= LINE_J;
            shifter       <= '0;
            bits_left     <= '0;
            stuff_cnt     <= '0;
            cur_last      <= 1'b0;
            hold_data     <= '0;
            hold_last     <= 1'b0;
            hold_full     <= 1'b0;
            last_acc      <= 1'b0;
            eop_cnt       <= 1'b0;
            tx_active     <= 1'b0;
            tx_data_ready <= 1'b0;
            tx_done       <= 1'b0;
            tx_error      <= 1'b0;
`ifdef USB_TX_CRC16_EN
            crc_phase     <= 2'd0;
`endif
        end else begin
            state         <= state_d;
            line          <= line_d;
            shifter       <= shifter_d;
            bits_left     <= bits_left_d;
            stuff_cnt     <= stuff_d;
            cur_last      <= cur_last_d;
            hold_data     <= hold_data_d;
            hold_last     <= hold_last_d;
            hold_full     <= hold_full_d;
            last_acc      <= last_acc_d;
            eop_cnt       <= eop_cnt_d;
            tx_active     <= (state_d != ST_IDLE);
            tx_data_ready <= ready_d;
            tx_done       <= done_d;
            tx_error      <= error_d;
`ifdef USB_TX_CRC16_EN
            crc_phase     <= crc_phase_d;
`endif
        end
    end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb/tb_usb_tx_serializer.sv - self-checking bench for usb_tx_serializer
module tb_usb_tx_serializer;
    import usb_tx_pkg::*;

    localparam int CPB = 8;
`ifdef USB_TX_CRC16_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic       dp_out;
    logic       dm_out;
    logic       tx_active;
    logic       tx_done;
    logic       tx_error;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q[$];
    logic [7:0] pkt[$];

    usb_tx_serializer #(
        .CLKS_PER_BIT (CPB),
        .STUFF_LEN    (6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_last       (tx_last),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .dp_out        (dp_out),
        .dm_out        (dm_out),
        .tx_active     (tx_active),
        .tx_done       (tx_done),
        .tx_error      (tx_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc16_model(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, pkt[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
            end
        end
        return c;
    endfunction

    // Raw bits -> stuffing -> NRZI, then SE0, SE0, J.
    task automatic build_expected(input int nbytes, input bit add_crc);
        logic        raw[$];
        logic [1:0]  ln;
        int          ones;
        logic [7:0]  sb;
        logic [15:0] crc;
        exp_q.delete();
        sb = SYNC_BYTE;
        for (int i = 0; i < 8; i++) raw.push_back(sb[i]);
        for (int k = 0; k < nbytes; k++) begin
            for (int i = 0; i < 8; i++) raw.push_back(pkt[k][i]);
        end
        if (add_crc) begin
            crc = ~crc16_model(nbytes);
            for (int i = 0; i < 16; i++) raw.push_back(crc[i]);
        end
        ln = LINE_J;
        ones = 0;
        foreach (raw[i]) begin
            if (!raw[i]) begin
                ln = (ln == LINE_J) ? LINE_K : LINE_J;
                ones = 0;
            end else begin
                ones++;
            end
            exp_q.push_back(ln);
            if (ones == 6) begin
                ln = (ln == LINE_J) ? LINE_K : LINE_J;
                ones = 0;
                exp_q.push_back(ln);
            end
        end
        exp_q.push_back(LINE_SE0);
        exp_q.push_back(LINE_SE0);
        exp_q.push_back(LINE_J);
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic run_packet(input int nfeed, input bit underrun, input int feed_delay,
                              input bit poke, input string name);
        int n;
        int err_c;
        build_expected(nfeed, CRC_ON && !underrun);
        n = exp_q.size();
        err_c = underrun ? 8 * (n - 3) : -1;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        fork
            begin
                repeat (feed_delay) @(negedge clk);
                for (int k = 0; k < nfeed; k++) begin
                    int w;
                    w = 0;
                    @(negedge clk);
                    while (!tx_data_ready && w < 400) begin
                        @(negedge clk);
                        w++;
                    end
                    check({name, " ready_wait"}, 32'(w < 400), 32'd1);
                    tx_data       = pkt[k];
                    tx_last       = !underrun && (k == nfeed - 1);
                    tx_data_valid = 1'b1;
                    @(negedge clk);
                    tx_data_valid = 1'b0;
                    tx_last       = 1'b0;
                    if (!underrun && k == nfeed - 1)
                        check({name, " ready_after_last"}, 32'(tx_data_ready), 32'd0);
                end
            end
            begin
                for (int c = 0; c <= 8 * n; c++) begin
                    if (c % 8 == 4)
                        check($sformatf("%s line bit %0d", name, c / 8),
                              32'({dp_out, dm_out}), 32'(exp_q.pop_front()));
                    check($sformatf("%s tx_done c=%0d", name, c), 32'(tx_done), 32'(c == 8 * n));
                    check($sformatf("%s tx_error c=%0d", name, c), 32'(tx_error), 32'(c == err_c));
                    if (c == 0 || c == 8 * n - 1 || c == 8 * n)
                        check($sformatf("%s tx_active c=%0d", name, c), 32'(tx_active), 32'(c < 8 * n));
                    if (poke && c == 40) tx_start = 1'b1;
                    if (poke && c == 41) tx_start = 1'b0;
                    if (c < 8 * n) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
        join
        check({name, " scoreboard empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int done_seen;
        int w;
        rst           = 1'b1;
        tx_start      = 1'b0;
        tx_data       = 8'h00;
        tx_last       = 1'b0;
        tx_data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset dp", 32'(dp_out), 32'd1);
        check("reset dm", 32'(dm_out), 32'd0);
        check("reset tx_active", 32'(tx_active), 32'd0);
        check("reset tx_data_ready", 32'(tx_data_ready), 32'd0);
        check("reset tx_done", 32'(tx_done), 32'd0);
        check("reset tx_error", 32'(tx_error), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        pkt = {8'h00};
        run_packet(1, 1'b0, 0, 1'b1, "p00");
        pkt = {8'hFF};
        run_packet(1, 1'b0, 0, 1'b0, "pFF");
        pkt = {8'hA5, 8'h3C};
        run_packet(2, 1'b0, 30, 1'b0, "pA53C");
        pkt = {8'hA5};
        run_packet(1, 1'b1, 0, 1'b0, "underrun");
        pkt = {8'($urandom), 8'($urandom), 8'($urandom)};
        run_packet(3, 1'b0, 0, 1'b0, "prand");

        // Reset mid-packet with a byte waiting in the holding register.
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            w = 0;
            @(negedge clk);
            while (!tx_data_ready && w < 400) begin
                @(negedge clk);
                w++;
            end
            check("rstmid ready_wait", 32'(w < 400), 32'd1);
            tx_data       = (k == 0) ? 8'h55 : 8'h66;
            tx_data_valid = 1'b1;
            @(negedge clk);
            tx_data_valid = 1'b0;
        end
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstmid dp", 32'(dp_out), 32'd1);
        check("rstmid dm", 32'(dm_out), 32'd0);
        check("rstmid tx_active", 32'(tx_active), 32'd0);
        check("rstmid tx_data_ready", 32'(tx_data_ready), 32'd0);
        done_seen = 0;
        for (int c = 0; c < 200; c++) begin
            if (tx_done || tx_error) done_seen++;
            @(posedge clk);
            #1;
        end
        check("rstmid no done/error", 32'(done_seen), 32'd0);

        pkt = {8'hC3};
        run_packet(1, 1'b0, 0, 1'b0, "after_rst");
`ifdef USB_TX_CRC16_EN
        pkt = {8'h00, 8'h01};
        run_packet(2, 1'b0, 0, 1'b0, "crc0001");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
